i2c_master_arbiter: RTL and testbench
=====================================

# i2c_master_arbiter

Shares the single I2C_Master core between two requesters: requester 0 is the Spartan-slave controller (menu-driven remote RAM transfers), requester 1 is the temperature-sensor poller. It grants ownership round-robin, muxes the owner's command bus onto the master and routes master status/read data back to the owner only. An optional watchdog aborts a transfer that stalls.

## Interface
- TIMEOUT_CYCLES, 50_000_000: watchdog limit in clk cycles (1 s at 50 MHz); used only with the watchdog compiled in.
- CNT_W, 26: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- req0 / req1  in  1  level request; held for the whole ownership period.
- gnt0 / gnt1  out  1  registered grant; at most one high.
- go0/go1, stop0/stop1, rw0/rw1  in  1 each  per-requester master commands.
- nbyte0/nbyte1  in  6  byte count (N_Byte).
- dev0/dev1  in  7  slave address.
- rptr0/rptr1  in  8  register pointer.
- dwr0/dwr1  in  8  write data.
- done0/done1, ready0/ready1, ack0/ack1  out  1 each  routed master status.
- drd0/drd1  out  8  routed read data.
- timeout0/timeout1  out  1  one-cycle watchdog abort pulse.
- m_go, m_stop, m_rw  out  1  to master.
- m_nbyte 6, m_dev 7, m_rptr 8, m_dwr 8  out  to master.
- m_done, m_ready, m_ack  in  1  from master.
- m_drd  in  8  from master.

## Operation
- States: IDLE, OWN, DRAIN. Owner index `own` and round-robin pointer `last` are registers.
- IDLE: gnt0=gnt1=0. If m_ready=1 and any req: single req wins; both req -> winner is the index != last. Next edge: gnt_own=1, state OWN. If m_ready=0, wait.
- OWN: all owner command fields pass to master combinationally from registered `own`; non-owner command inputs ignored. Owner sees done/ready/ack/drd from master; non-owner sees done=ready=ack=0, drd=0.
- OWN -> DRAIN when req_own=0.
- DRAIN: grant held, m_go forced 0; when m_ready=1, next edge -> IDLE, gnt cleared, last=own. DRAIN lasts >=1 cycle.
- No outputs to master in IDLE: m_go=m_stop=m_rw=0, buses 0.
- Requester rule: raise go only while its gnt=1; drop req only after its final done.

## Timing
- Reset values: gnt0/1=0, timeout0/1=0, done/ready/ack/drd to both requesters 0, all master outputs 0, state IDLE, last=1 (requester 0 wins first contention), watchdog count 0.
- Request to grant: 1 cycle after req seen with m_ready=1 in IDLE.
- Command pass-through latency: 0 cycles (mux on registered own). Status return latency: 0 cycles.
- Release: req drop -> gnt drop earliest 2 edges later (OWN->DRAIN, DRAIN->IDLE).
- Back-to-back: a waiting requester is granted 1 cycle after IDLE entry; no requester is granted twice in a row while the other requests.
- Reset mid-transfer: on the reset edge everything returns to reset values; master is not sent stop (master reset is shared).

## Configuration
- I2C_ARB_WATCHDOG_EN defined: counter clears on entering OWN and on every m_done; increments each OWN cycle; at TIMEOUT_CYCLES-1 the arbiter drives m_stop=1 for one cycle, pulses timeout_own for that cycle, and enters DRAIN regardless of req_own. The requester must drop req after timeout.
- Undefined: no counter, timeout0/1 tied 0, OWN exits only on req drop.

## Structure
- Package i2c_arb_pkg: state enum (IDLE, OWN, DRAIN), requester index constants REQ_SPARTAN=0, REQ_TEMP=1, field widths (NBYTE_W=6, DEV_W=7, BYTE_W=8).
- One sub-module: i2c_arb_watchdog (counter, clear, expiry pulse), instantiated only under I2C_ARB_WATCHDOG_EN.

## Test plan
- req0 alone, m_ready=1 -> gnt0=1 one cycle later; go0 with dev0=0x48, rptr0=0x00 appears on m_go/m_dev/m_rptr same cycle; done1 stays 0.
- req0 and req1 raised same cycle after reset -> gnt0 first; after req0 drop and m_ready=1, gnt1 exactly 1 cycle after IDLE; next simultaneous request -> gnt0 (alternation).
- Owner req1 drops while m_ready=0 for 10 cycles -> gnt1 held, m_go=0 throughout DRAIN; gnt1 clears on edge after m_ready=1.
- Non-owner toggles go1, dev1=0x7F during gnt0 -> m_go/m_dev unaffected.
- Watchdog on, TIMEOUT_CYCLES=16, m_done never pulses -> m_stop=1 and timeout0=1 on 16th OWN cycle, state DRAIN; with m_done every 10 cycles -> no timeout.
- reset asserted mid-OWN -> next edge all gnt, timeout, master outputs 0, state IDLE, requester 0 wins next contention.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-requester I2C master arbiter.
// Optional watchdog is enabled by defining I2C_ARB_WATCHDOG_EN.
package i2c_arb_pkg;

    localparam int unsigned NBYTE_W = 6;
    localparam int unsigned DEV_W   = 7;
    localparam int unsigned BYTE_W  = 8;

    localparam logic REQ_SPARTAN = 1'b0;
    localparam logic REQ_TEMP    = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StOwn   = 2'd1,
        StDrain = 2'd2
    } arb_state_e;

    // Single requester wins outright; on contention the one not served last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (&req) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Bundle of requester-side and master-side signals around the I2C master arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface i2c_master_arbiter_if;
    import i2c_arb_pkg::*;

    // Requester 0 (Spartan-slave controller)
    logic              req0;
    logic              gnt0;
    logic              go0;
    logic              stop0;
    logic              rw0;
    logic [NBYTE_W-1:0] nbyte0;
    logic [DEV_W-1:0]  dev0;
    logic [BYTE_W-1:0] rptr0;
    logic [BYTE_W-1:0] dwr0;
    logic              done0;
    logic              ready0;
    logic              ack0;
    logic [BYTE_W-1:0] drd0;
    logic              timeout0;

    // Requester 1 (temperature poller)
    logic              req1;
    logic              gnt1;
    logic              go1;
    logic              stop1;
    logic              rw1;
    logic [NBYTE_W-1:0] nbyte1;
    logic [DEV_W-1:0]  dev1;
    logic [BYTE_W-1:0] rptr1;
    logic [BYTE_W-1:0] dwr1;
    logic              done1;
    logic              ready1;
    logic              ack1;
    logic [BYTE_W-1:0] drd1;
    logic              timeout1;

    // Shared I2C master core
    logic              m_go;
    logic              m_stop;
    logic              m_rw;
    logic [NBYTE_W-1:0] m_nbyte;
    logic [DEV_W-1:0]  m_dev;
    logic [BYTE_W-1:0] m_rptr;
    logic [BYTE_W-1:0] m_dwr;
    logic              m_done;
    logic              m_ready;
    logic              m_ack;
    logic [BYTE_W-1:0] m_drd;

    modport slave (
        input  req0, go0, stop0, rw0, nbyte0, dev0, rptr0, dwr0,
        input  req1, go1, stop1, rw1, nbyte1, dev1, rptr1, dwr1,
        output gnt0, done0, ready0, ack0, drd0, timeout0,
        output gnt1, done1, ready1, ack1, drd1, timeout1,
        output m_go, m_stop, m_rw, m_nbyte, m_dev, m_rptr, m_dwr,
        input  m_done, m_ready, m_ack, m_drd
    );

    modport master (
        output req0, go0, stop0, rw0, nbyte0, dev0, rptr0, dwr0,
        output req1, go1, stop1, rw1, nbyte1, dev1, rptr1, dwr1,
        input  gnt0, done0, ready0, ack0, drd0, timeout0,
        input  gnt1, done1, ready1, ack1, drd1, timeout1,
        input  m_go, m_stop, m_rw, m_nbyte, m_dev, m_rptr, m_dwr,
        output m_done, m_ready, m_ack, m_drd
    );

endinterface

// File: rtl/i2c_arb_watchdog.sv
// Stall watchdog for the arbiter: counts owned cycles since the last m_done and
// flags expiry on the cycle the count reaches TIMEOUT_CYCLES-1 (used with I2C_ARB_WATCHDOG_EN).
module i2c_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned CNT_W          = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic clear,
    output logic expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Held at zero outside ownership, so every new ownership period starts fresh.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!active || clear) begin
            cnt_d = '0;
        end
    end

    assign expire = active && (cnt_q == LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master between two requesters.
// Define I2C_ARB_WATCHDOG_EN to build in the stall watchdog (i2c_arb_watchdog).
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned CNT_W          = 26
) (
    input logic                  clk,
    input logic                  reset,
    i2c_master_arbiter_if.slave  bus
);

    if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cfg_check
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    arb_state_e state_q;
    arb_state_e state_d;
    logic       own_q;
    logic       own_d;
    logic       last_q;
    logic       last_d;
    logic [1:0] gnt_q;
    logic [1:0] gnt_d;
    logic [1:0] req;
    logic       req_own;
    logic       expire;

    assign req     = {bus.req1, bus.req0};
    assign req_own = req[own_q];

`ifdef I2C_ARB_WATCHDOG_EN
    i2c_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .active (state_q == StOwn),
        .clear  (bus.m_done),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin : next_state
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (bus.m_ready && (|req)) begin
                    own_d   = rr_pick(req, last_q);
                    state_d = StOwn;
                end
            end
            StOwn: begin
                if (expire || !req_own) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (bus.m_ready) begin
                    state_d = StIdle;
                    last_d  = own_q;
                end
            end
            default: state_d = StIdle;
        endcase
        gnt_d = '0;
        if (state_d != StIdle) begin
            gnt_d[own_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            own_q   <= REQ_SPARTAN;
            last_q  <= REQ_TEMP;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.gnt0 = gnt_q[0];
    assign bus.gnt1 = gnt_q[1];

    // Command mux keyed on the registered owner; go is suppressed while draining.
    always_comb begin : master_mux
        bus.m_go    = 1'b0;
        bus.m_stop  = 1'b0;
        bus.m_rw    = 1'b0;
        bus.m_nbyte = '0;
        bus.m_dev   = '0;
        bus.m_rptr  = '0;
        bus.m_dwr   = '0;
        if (state_q != StIdle) begin
            if (own_q == REQ_TEMP) begin
                bus.m_go    = (state_q == StOwn) && bus.go1;
                bus.m_stop  = bus.stop1 | expire;
                bus.m_rw    = bus.rw1;
                bus.m_nbyte = bus.nbyte1;
                bus.m_dev   = bus.dev1;
                bus.m_rptr  = bus.rptr1;
                bus.m_dwr   = bus.dwr1;
            end else begin
                bus.m_go    = (state_q == StOwn) && bus.go0;
                bus.m_stop  = bus.stop0 | expire;
                bus.m_rw    = bus.rw0;
                bus.m_nbyte = bus.nbyte0;
                bus.m_dev   = bus.dev0;
                bus.m_rptr  = bus.rptr0;
                bus.m_dwr   = bus.dwr0;
            end
        end
    end

    always_comb begin : status_route
        bus.done0    = 1'b0;
        bus.ready0   = 1'b0;
        bus.ack0     = 1'b0;
        bus.drd0     = '0;
        bus.done1    = 1'b0;
        bus.ready1   = 1'b0;
        bus.ack1     = 1'b0;
        bus.drd1     = '0;
        bus.timeout0 = expire && (own_q == REQ_SPARTAN);
        bus.timeout1 = expire && (own_q == REQ_TEMP);
        if (state_q != StIdle) begin
            if (own_q == REQ_TEMP) begin
                bus.done1  = bus.m_done;
                bus.ready1 = bus.m_ready;
                bus.ack1   = bus.m_ack;
                bus.drd1   = bus.m_drd;
            end else begin
                bus.done0  = bus.m_done;
                bus.ready0 = bus.m_ready;
                bus.ack0   = bus.m_ack;
                bus.drd0   = bus.m_drd;
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Randomised scoreboard bench for i2c_master_arbiter; the watchdog scenario runs
// only when I2C_ARB_WATCHDOG_EN is defined.
module tb_i2c_master_arbiter;
    import i2c_arb_pkg::*;

    typedef struct packed {
        logic               go;
        logic               stop;
        logic               rw;
        logic [NBYTE_W-1:0] nbyte;
        logic [DEV_W-1:0]   dev;
        logic [BYTE_W-1:0]  rptr;
        logic [BYTE_W-1:0]  dwr;
    } cmd_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i2c_master_arbiter_if bus ();

    i2c_master_arbiter #(
        .TIMEOUT_CYCLES (16),
        .CNT_W          (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_owner_q[$];
    int last_m = 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic gnt_of(input int who);
        return (who == 1) ? bus.gnt1 : bus.gnt0;
    endfunction

    task automatic set_req(input int who, input logic v);
        if (who == 1) bus.req1 = v;
        else bus.req0 = v;
    endtask

    task automatic drive(input int who, input cmd_t c);
        if (who == 1) begin
            bus.go1 = c.go; bus.stop1 = c.stop; bus.rw1 = c.rw; bus.nbyte1 = c.nbyte;
            bus.dev1 = c.dev; bus.rptr1 = c.rptr; bus.dwr1 = c.dwr;
        end else begin
            bus.go0 = c.go; bus.stop0 = c.stop; bus.rw0 = c.rw; bus.nbyte0 = c.nbyte;
            bus.dev0 = c.dev; bus.rptr0 = c.rptr; bus.dwr0 = c.dwr;
        end
    endtask

    task automatic check_master(input cmd_t c);
        check("m_go", 32'(bus.m_go), 32'(c.go));
        check("m_stop", 32'(bus.m_stop), 32'(c.stop));
        check("m_rw", 32'(bus.m_rw), 32'(c.rw));
        check("m_nbyte", 32'(bus.m_nbyte), 32'(c.nbyte));
        check("m_dev", 32'(bus.m_dev), 32'(c.dev));
        check("m_rptr", 32'(bus.m_rptr), 32'(c.rptr));
        check("m_dwr", 32'(bus.m_dwr), 32'(c.dwr));
    endtask

    task automatic check_status(input int who);
        logic [10:0] own_s, oth_s, exp_s;
        exp_s = {bus.m_done, bus.m_ready, bus.m_ack, bus.m_drd};
        own_s = (who == 1) ? {bus.done1, bus.ready1, bus.ack1, bus.drd1}
                           : {bus.done0, bus.ready0, bus.ack0, bus.drd0};
        oth_s = (who == 1) ? {bus.done0, bus.ready0, bus.ack0, bus.drd0}
                           : {bus.done1, bus.ready1, bus.ack1, bus.drd1};
        check("owner_status", 32'(own_s), 32'(exp_s));
        check("nonowner_status", 32'(oth_s), 32'd0);
        check("timeout_quiet", 32'({bus.timeout1, bus.timeout0}), 32'd0);
    endtask

    // Entered just after a negedge with the arbiter idle and req[who] already raised.
    task automatic serve(input int who);
        cmd_t c;
        cmd_t junk;
        int   w;
        int   n;
        @(negedge clk); #1;
        check("grant_latency", 32'(gnt_of(who)), 32'd1);
        check("other_gnt_low", 32'(gnt_of(1 - who)), 32'd0);
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c    = cmd_t'($urandom);
            junk = cmd_t'($urandom);
            drive(who, c);
            drive(1 - who, junk);
            bus.m_done  = 1'($urandom);
            bus.m_ready = 1'($urandom);
            bus.m_ack   = 1'($urandom);
            bus.m_drd   = 8'($urandom);
            #1;
            check_master(c);
            check_status(who);
        end
        w = $urandom_range(0, 4);
        @(negedge clk);
        set_req(who, 1'b0);
        c.go = 1'b1;
        drive(who, c);
        bus.m_ready = (w == 0);
        bus.m_done  = 1'b0;
        for (int k = 1; k <= ((w == 0) ? 1 : w); k++) begin
            @(negedge clk); #1;
            check("drain_gnt_held", 32'(gnt_of(who)), 32'd1);
            check("drain_go_forced", 32'(bus.m_go), 32'd0);
            if (k == w) bus.m_ready = 1'b1;
        end
        @(negedge clk); #1;
        check("release_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        check("idle_master_go", 32'(bus.m_go), 32'd0);
        drive(0, '0);
        drive(1, '0);
    endtask

    // pattern: bit0 = requester 0 asks, bit1 = requester 1 asks.
    task automatic round(input int pattern);
        int first;
        int second;
        bus.m_ready = 1'b1;
        if (pattern == 3) begin
            first  = (last_m == 0) ? 1 : 0;
            second = 1 - first;
            exp_owner_q.push_back(first);
            exp_owner_q.push_back(second);
            bus.req0 = 1'b1;
            bus.req1 = 1'b1;
            serve(first);
            serve(second);
            last_m = second;
        end else begin
            first = (pattern == 2) ? 1 : 0;
            exp_owner_q.push_back(first);
            set_req(first, 1'b1);
            serve(first);
            last_m = first;
        end
    endtask

    // Monitor: every new grant must match the next owner the model predicted.
    initial begin
        logic [1:0] prev;
        logic [1:0] cur;
        int         e;
        prev = '0;
        forever begin
            @(posedge clk); #1;
            cur = {bus.gnt1, bus.gnt0};
            if (cur != prev && cur != 2'b00) begin
                if (exp_owner_q.size() == 0) begin
                    check("grant_unexpected", 32'(cur), 32'd0);
                end else begin
                    e = exp_owner_q.pop_front();
                    check("grant_order", 32'(cur), 32'(2'b01 << e));
                end
            end
            prev = cur;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        cmd_t c;
        reset = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        drive(0, '0); drive(1, '0);
        bus.m_done = 1'b0; bus.m_ready = 1'b1; bus.m_ack = 1'b1; bus.m_drd = 8'hA5;
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        check("rst_timeout", 32'({bus.timeout1, bus.timeout0}), 32'd0);
        check("rst_status0", 32'({bus.done0, bus.ready0, bus.ack0, bus.drd0}), 32'd0);
        check("rst_status1", 32'({bus.done1, bus.ready1, bus.ack1, bus.drd1}), 32'd0);
        check("rst_master", 32'({bus.m_go, bus.m_stop, bus.m_rw, bus.m_dev, bus.m_rptr}), 32'd0);
        reset = 1'b0;
        bus.m_ack = 1'b0; bus.m_drd = '0;

        round(3);
        for (int r = 0; r < 12; r++) round($urandom_range(1, 3));

        // Reset while requester 0 owns the master.
        bus.m_ready = 1'b1;
        exp_owner_q.push_back(0);
        set_req(0, 1'b1);
        @(negedge clk); #1;
        check("pre_reset_gnt0", 32'(bus.gnt0), 32'd1);
        c = cmd_t'($urandom);
        c.go = 1'b1;
        drive(0, c);
        bus.m_done = 1'b1;
        reset = 1'b1;
        @(negedge clk); #1;
        check("midrst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        check("midrst_master", 32'({bus.m_go, bus.m_stop, bus.m_dev, bus.m_rptr}), 32'd0);
        check("midrst_done0", 32'(bus.done0), 32'd0);
        check("midrst_timeout", 32'({bus.timeout1, bus.timeout0}), 32'd0);
        reset = 1'b0;
        set_req(0, 1'b0);
        drive(0, '0);
        bus.m_done = 1'b0;
        last_m = 1;
        round(3);

`ifdef I2C_ARB_WATCHDOG_EN
        // Stalled transfer: no m_done, watchdog fires on the 16th owned cycle.
        bus.m_ready = 1'b1;
        exp_owner_q.push_back(0);
        set_req(0, 1'b1);
        c = '0;
        c.go = 1'b1;
        drive(0, c);
        @(negedge clk); #1;
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) begin
                @(negedge clk); #1;
            end
            check("wd_timeout0", 32'(bus.timeout0), (k == 16) ? 32'd1 : 32'd0);
            check("wd_stop", 32'(bus.m_stop), (k == 16) ? 32'd1 : 32'd0);
        end
        @(negedge clk); #1;
        check("wd_drain_gnt", 32'(bus.gnt0), 32'd1);
        check("wd_drain_go", 32'(bus.m_go), 32'd0);
        check("wd_pulse_once", 32'(bus.timeout0), 32'd0);
        set_req(0, 1'b0);
        drive(0, '0);
        @(negedge clk); #1;
        check("wd_release", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        last_m = 0;

        // Periodic m_done keeps the watchdog from firing.
        exp_owner_q.push_back(0);
        set_req(0, 1'b1);
        drive(0, c);
        @(negedge clk); #1;
        for (int k = 1; k <= 40; k++) begin
            check("wd_no_timeout", 32'(bus.timeout0), 32'd0);
            @(negedge clk);
            bus.m_done = (k % 10 == 0);
            #1;
        end
        check("wd_still_owned", 32'(bus.gnt0), 32'd1);
        bus.m_done = 1'b0;
        set_req(0, 1'b0);
        drive(0, '0);
        repeat (2) @(negedge clk);
        #1;
        check("wd_release2", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        last_m = 0;
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_owner_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
